// File: rtl/cb_pkg.sv
// Shared types and constants for the cb shift-add multiplier.
// Holds the controller state encoding and the default operand width.
package cb_pkg;

  localparam int CB_WIDTH = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cb_adder.sv
// W-bit unsigned adder with carry-out.
// Used for the partial-sum update of the multiplier.
module cb_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] total_s;

  // W+1-bit addition so the carry is kept
  always_comb begin
    total_s = {1'b0, x} + {1'b0, y};
  end

  assign sum = total_s[W-1:0];
  assign co  = total_s[W];

endmodule

// File: rtl/cb.sv
// Sequential shift-add unsigned multiplier: LOAD, WIDTH x STEP, DONE.
// Any operand change after LOAD aborts the product and suppresses the strobe.
module cb
  import cb_pkg::*;
#(
  parameter int WIDTH = CB_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               c,
  output logic               cout,
  output logic [2*WIDTH-1:0] acc
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_r;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplr_q;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic                 cout_r;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 carry_s;
  logic                 changed_s;
  logic                 c_s;

  // Partial-sum addend and operand-change detection
  always_comb begin
    changed_s = (a != mcand_q) || (b != mplr_q);
    if (acc_r[0]) begin
      addend_s = mcand_q;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
  end

  cb_adder #(.W(WIDTH)) u_adder (
    .x   (acc_r[2*WIDTH-1:WIDTH]),
    .y   (addend_s),
    .sum (sum_s),
    .co  (carry_s)
  );

  // Strobe is gated by the live operand compare so a change during DONE is never flagged
  always_comb begin
    if ((state_r == DONE) && !changed_s) begin
      c_s = 1'b1;
    end else begin
      c_s = 1'b0;
    end
  end

  // Controller, operand latches, accumulator and carry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD;
      mcand_q <= {WIDTH{1'b0}};
      mplr_q  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          mcand_q <= a;
          mplr_q  <= b;
          acc_r   <= {{WIDTH{1'b0}}, b};
          cnt_r   <= {CW{1'b0}};
          cout_r  <= 1'b0;
          state_r <= STEP;
        end
        STEP: begin
          if (changed_s) begin
            state_r <= LOAD;
          end else begin
            acc_r  <= {carry_s, sum_s, acc_r[WIDTH-1:1]};
            cout_r <= carry_s;
            cnt_r  <= cnt_r + CW'(1);
            if (cnt_r == LAST) begin
              state_r <= DONE;
            end else begin
              state_r <= STEP;
            end
          end
        end
        DONE: begin
          state_r <= LOAD;
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

  assign c    = c_s;
  assign cout = cout_r;
  assign acc  = acc_r;

endmodule

// File: tb/tb_cb.sv
// Scoreboard bench for cb: expected products queued on drive, popped on each c strobe.
module tb_cb;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        c;
  logic        cout;
  logic [15:0] acc;

  logic [15:0] exp_q[$];
  int          n_cmp;
  int          n_bad;
  bit          seen_cout;

  cb #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .cout (cout),
    .acc  (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cout) seen_cout = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // wait for c, compare against the scoreboard head, then check the hold cycle
  task automatic wait_c(input bit check_lat);
    int cyc;
    bit got;
    logic [15:0] e;
    cyc = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (c) got = 1'b1;
    end
    if (!got) begin
      chk("timeout", 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      chk("spurious_c", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("acc", {16'd0, acc}, {16'd0, e});
      if (check_lat) chk("latency", cyc, 32'd10);
      @(negedge clk);
      chk("acc_hold", {16'd0, acc}, {16'd0, e});
      chk("c_low_after", {31'd0, c}, 32'd0);
    end
  endtask

  task automatic op(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    exp_q.push_back({8'd0, av} * {8'd0, bv});
    wait_c(1'b1);
  endtask

  logic [7:0] tab_a [12] = '{8'd1, 8'd1, 8'd5, 8'd5, 8'd5, 8'd100, 8'd100, 8'd127, 8'd0, 8'd0, 8'd37, 8'd200};
  logic [7:0] tab_b [12] = '{8'd100, 8'd127, 8'd10, 8'd100, 8'd127, 8'd100, 8'd127, 8'd127, 8'd5, 8'd0, 8'd211, 8'd1};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    seen_cout = 1'b0;
    rst_n = 1'b0;
    a = 8'd0;
    b = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_acc", {16'd0, acc}, 32'd0);
    chk("rst_c", {31'd0, c}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);

    // first product straight out of reset
    a = 8'd1;
    b = 8'd6;
    rst_n = 1'b1;
    exp_q.push_back(16'd6);
    wait_c(1'b1);
    chk("cout_1x6", {31'd0, cout}, 32'd0);

    for (int i = 0; i < 12; i++) op(tab_a[i], tab_b[i]);

    seen_cout = 1'b0;
    op(8'd255, 8'd255);
    chk("cout_seen", {31'd0, seen_cout}, 32'd1);

    // b changes mid-STEP: the 1x6 product must never be flagged
    a = 8'd1;
    b = 8'd6;
    repeat (5) @(negedge clk);
    chk("no_c_mid", {31'd0, c}, 32'd0);
    b = 8'd100;
    exp_q.push_back(16'd100);
    wait_c(1'b0);

    // operands change during the DONE cycle itself
    a = 8'd3;
    b = 8'd7;
    repeat (9) @(negedge clk);
    chk("pre_done_c", {31'd0, c}, 32'd1);
    a = 8'd5;
    b = 8'd10;
    #1;
    chk("done_abort_c", {31'd0, c}, 32'd0);
    exp_q.push_back(16'd50);
    wait_c(1'b0);

    // reset mid-operation
    a = 8'd255;
    b = 8'd255;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", {16'd0, acc}, 32'd0);
    chk("midrst_c", {31'd0, c}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    a = 8'd13;
    b = 8'd17;
    rst_n = 1'b1;
    exp_q.push_back(16'd221);
    wait_c(1'b1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
